// File: rtl/vector_lane_sequencer_pkg.sv
// rtl/vector_lane_sequencer_pkg.sv - shared sizes, state encoding and element/group helpers
package vector_lane_sequencer_pkg;

    localparam int LEN              = 32;
    localparam int VECTOR_SIZE      = 8;
    localparam int ENTRY_INDEX_SIZE = 3;
    localparam int LANE_INDEX_SIZE  = 1;
    localparam int LANE_NUM         = 2 ** LANE_INDEX_SIZE;
    localparam int GROUP_NUM        = VECTOR_SIZE / LANE_NUM;
    localparam int GROUP_INDEX_SIZE = (ENTRY_INDEX_SIZE > LANE_INDEX_SIZE) ?
                                      (ENTRY_INDEX_SIZE - LANE_INDEX_SIZE) : 1;

    typedef logic [ENTRY_INDEX_SIZE:0]     vl_t;
    typedef logic [GROUP_INDEX_SIZE-1:0]   group_t;
    typedef logic [VECTOR_SIZE*LEN-1:0]    vec_t;
    typedef logic [LANE_NUM*LEN-1:0]       lane_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic   found;
        group_t idx;
    } group_pick_t;

    // Element i of a packed register vector.
    function automatic logic [LEN-1:0] elem_get(input vec_t v, input int i);
        return v[i*LEN +: LEN];
    endfunction

    // vl can encode values above the register length; anything beyond is meaningless.
    function automatic vl_t clamp_vl(input vl_t vl);
        return (vl > vl_t'(VECTOR_SIZE)) ? vl_t'(VECTOR_SIZE) : vl;
    endfunction

    // A group is worth a cycle only if it holds at least one live, enabled element.
    function automatic logic group_enabled(input int g, input vl_t vl, input logic vm,
                                           input logic [VECTOR_SIZE-1:0] mask);
        logic en;
        int   e;
        en = 1'b0;
        for (int l = 0; l < LANE_NUM; l++) begin
            e = g * LANE_NUM + l;
            if ((e < int'(vl)) && (vm || mask[e])) begin
                en = 1'b1;
            end
        end
        return en;
    endfunction

    // Lowest enabled group at or above 'from'.
    function automatic group_pick_t find_group(input int from, input vl_t vl, input logic vm,
                                               input logic [VECTOR_SIZE-1:0] mask);
        group_pick_t pick;
        pick = '0;
        for (int g = GROUP_NUM - 1; g >= 0; g--) begin
            if ((g >= from) && group_enabled(g, vl, vm, mask)) begin
                pick.found = 1'b1;
                pick.idx   = group_t'(g);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/vector_lane_sequencer_if.sv
// rtl/vector_lane_sequencer_if.sv - instruction, lane broadcast and writeback bus of the sequencer
// slave  : sequencer side (takes instruction + lane results, drives lanes + writeback)
// master : upstream/lane/writeback side
interface vector_lane_sequencer_if;
    import vector_lane_sequencer_pkg::*;

    logic                   start_valid;
    logic                   start_ready;
    vl_t                    vl;
    logic                   vm;
    logic [VECTOR_SIZE-1:0] mask_bits;
    vec_t                   vs1_data;
    vec_t                   vs2_data;
    logic [LEN-1:0]         imm;
    logic [LEN-1:0]         rs;
    logic [2:0]             alu_signal;
    logic [1:0]             vec_operand_type;
    logic [5:0]             funct6;

    lane_vec_t              lane_vs1;
    lane_vec_t              lane_vs2;
    lane_vec_t              lane_mask;
    logic [LEN-1:0]         lane_imm;
    logic [LEN-1:0]         lane_rs;
    logic [2:0]             lane_alu_signal;
    logic [1:0]             lane_operand_type;
    logic [5:0]             lane_funct6;
    logic [LANE_NUM-1:0]    lane_active;
    lane_vec_t              lane_result;

    logic                   result_valid;
    logic                   result_ready;
    vec_t                   result_data;
    logic [VECTOR_SIZE-1:0] result_we;
    logic                   busy;

    modport slave (
        input  start_valid, vl, vm, mask_bits, vs1_data, vs2_data, imm, rs,
               alu_signal, vec_operand_type, funct6, lane_result, result_ready,
        output start_ready, lane_vs1, lane_vs2, lane_mask, lane_imm, lane_rs,
               lane_alu_signal, lane_operand_type, lane_funct6, lane_active,
               result_valid, result_data, result_we, busy
    );

    modport master (
        output start_valid, vl, vm, mask_bits, vs1_data, vs2_data, imm, rs,
               alu_signal, vec_operand_type, funct6, lane_result, result_ready,
        input  start_ready, lane_vs1, lane_vs2, lane_mask, lane_imm, lane_rs,
               lane_alu_signal, lane_operand_type, lane_funct6, lane_active,
               result_valid, result_data, result_we, busy
    );

endinterface

// File: rtl/vector_lane_sequencer_group_select.sv
// rtl/vector_lane_sequencer_group_select.sv - combinational per-group lane operand select and next-group search
// Macro: VECTOR_SEQ_GROUP_SKIP_EN selects masked-group skipping for the next-group search.
// Ports: group_i, vs1_i, vs2_i, vl_i, vm_i, mask_i in; lane_vs1_o, lane_vs2_o, lane_mask_o,
//        lane_active_o, lane_we_o, next_found_o, next_group_o out.
module vector_group_select
    import vector_lane_sequencer_pkg::*;
(
    input  group_t                 group_i,
    input  vec_t                   vs1_i,
    input  vec_t                   vs2_i,
    input  vl_t                    vl_i,
    input  logic                   vm_i,
    input  logic [VECTOR_SIZE-1:0] mask_i,
    output lane_vec_t              lane_vs1_o,
    output lane_vec_t              lane_vs2_o,
    output lane_vec_t              lane_mask_o,
    output logic [LANE_NUM-1:0]    lane_active_o,
    output logic [LANE_NUM-1:0]    lane_we_o,
    output logic                   next_found_o,
    output group_t                 next_group_o
);

    int   e;
    logic en;

    always_comb begin
        lane_vs1_o    = '0;
        lane_vs2_o    = '0;
        lane_mask_o   = '0;
        lane_active_o = '0;
        lane_we_o     = '0;
        e             = 0;
        en            = 1'b0;
        for (int l = 0; l < LANE_NUM; l++) begin
            e  = int'(group_i) * LANE_NUM + l;
            en = vm_i | mask_i[e];
            lane_vs1_o[l*LEN +: LEN]  = elem_get(vs1_i, e);
            lane_vs2_o[l*LEN +: LEN]  = elem_get(vs2_i, e);
            lane_mask_o[l*LEN +: LEN] = {{(LEN-1){1'b0}}, en};
            lane_active_o[l]          = (e < int'(vl_i));
            lane_we_o[l]              = (e < int'(vl_i)) && en;
        end
    end

`ifdef VECTOR_SEQ_GROUP_SKIP_EN
    group_pick_t pick;

    always_comb begin
        pick         = find_group(int'(group_i) + 1, vl_i, vm_i, mask_i);
        next_found_o = pick.found;
        next_group_o = pick.idx;
    end
`else
    always_comb begin
        next_found_o = ((int'(group_i) + 1) * LANE_NUM) < int'(vl_i);
        next_group_o = group_i + group_t'(1);
    end
`endif

endmodule

// File: rtl/vector_lane_sequencer.sv
// rtl/vector_lane_sequencer.sv - issue-side sequencer stepping a vector instruction over the lane ALUs
// Macro: VECTOR_SEQ_GROUP_SKIP_EN - groups with no enabled element cost no EXEC cycle.
// Ports: clk, rst_n (sync active-low); bus (vector_lane_sequencer_if.slave): instruction
//        handshake start_valid/start_ready + operands, lane broadcast lane_* / lane_active,
//        lane_result from the ALUs, writeback result_valid/result_ready/result_data/result_we, busy.
module vector_lane_sequencer
    import vector_lane_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    vector_lane_sequencer_if.slave  bus
);

    seq_state_e             state_q;
    group_t                 group_q;
    vl_t                    vl_q;
    logic                   vm_q;
    logic [VECTOR_SIZE-1:0] mask_q;
    vec_t                   vs1_q;
    vec_t                   vs2_q;
    logic [LEN-1:0]         imm_q;
    logic [LEN-1:0]         rs_q;
    logic [2:0]             alu_q;
    logic [1:0]             optype_q;
    logic [5:0]             funct6_q;
    vec_t                   result_q;
    logic [VECTOR_SIZE-1:0] we_q;
    logic                   start_ready_q;
    logic                   result_valid_q;
    logic                   busy_q;

    vl_t                    vl_in_c;
    group_pick_t            first_c;
    logic                   exec_c;

    lane_vec_t              sel_vs1;
    lane_vec_t              sel_vs2;
    lane_vec_t              sel_mask;
    logic [LANE_NUM-1:0]    sel_active;
    logic [LANE_NUM-1:0]    sel_we;
    logic                   sel_next_found;
    group_t                 sel_next_group;

    vector_group_select u_group_select (
        .group_i       (group_q),
        .vs1_i         (vs1_q),
        .vs2_i         (vs2_q),
        .vl_i          (vl_q),
        .vm_i          (vm_q),
        .mask_i        (mask_q),
        .lane_vs1_o    (sel_vs1),
        .lane_vs2_o    (sel_vs2),
        .lane_mask_o   (sel_mask),
        .lane_active_o (sel_active),
        .lane_we_o     (sel_we),
        .next_found_o  (sel_next_found),
        .next_group_o  (sel_next_group)
    );

    assign exec_c  = (state_q == EXEC);
    assign vl_in_c = clamp_vl(bus.vl);

    // First group to execute; not found means the instruction goes straight to DONE.
`ifdef VECTOR_SEQ_GROUP_SKIP_EN
    assign first_c = find_group(0, vl_in_c, bus.vm, bus.mask_bits);
`else
    assign first_c = {(vl_in_c != '0), group_t'(0)};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            group_q        <= '0;
            vl_q           <= '0;
            vm_q           <= 1'b0;
            mask_q         <= '0;
            vs1_q          <= '0;
            vs2_q          <= '0;
            imm_q          <= '0;
            rs_q           <= '0;
            alu_q          <= '0;
            optype_q       <= '0;
            funct6_q       <= '0;
            result_q       <= '0;
            we_q           <= '0;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        vl_q          <= vl_in_c;
                        vm_q          <= bus.vm;
                        mask_q        <= bus.mask_bits;
                        vs1_q         <= bus.vs1_data;
                        vs2_q         <= bus.vs2_data;
                        imm_q         <= bus.imm;
                        rs_q          <= bus.rs;
                        alu_q         <= bus.alu_signal;
                        optype_q      <= bus.vec_operand_type;
                        funct6_q      <= bus.funct6;
                        result_q      <= '0;
                        we_q          <= '0;
                        group_q       <= first_c.idx;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        if (first_c.found) begin
                            state_q <= EXEC;
                        end else begin
                            state_q        <= DONE;
                            result_valid_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // Only enabled live elements are written; others stay zero from the accept clear.
                    for (int l = 0; l < LANE_NUM; l++) begin
                        if (sel_we[l]) begin
                            result_q[(int'(group_q) * LANE_NUM + l) * LEN +: LEN] <= bus.lane_result[l*LEN +: LEN];
                            we_q[int'(group_q) * LANE_NUM + l] <= 1'b1;
                        end
                    end
                    if (sel_next_found) begin
                        group_q <= sel_next_group;
                    end else begin
                        state_q        <= DONE;
                        result_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state_q        <= IDLE;
                        result_valid_q <= 1'b0;
                        start_ready_q  <= 1'b1;
                        busy_q         <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.lane_vs1          = exec_c ? sel_vs1    : '0;
    assign bus.lane_vs2          = exec_c ? sel_vs2    : '0;
    assign bus.lane_mask         = exec_c ? sel_mask   : '0;
    assign bus.lane_active       = exec_c ? sel_active : '0;
    assign bus.lane_imm          = exec_c ? imm_q      : '0;
    assign bus.lane_rs           = exec_c ? rs_q       : '0;
    assign bus.lane_alu_signal   = exec_c ? alu_q      : '0;
    assign bus.lane_operand_type = exec_c ? optype_q   : '0;
    assign bus.lane_funct6       = exec_c ? funct6_q   : '0;

    assign bus.start_ready  = start_ready_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_data  = result_q;
    assign bus.result_we    = we_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// tb/tb_vector_lane_sequencer.sv - scoreboard bench for vector_lane_sequencer with an adding lane model
module tb_vector_lane_sequencer;
    import vector_lane_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vector_lane_sequencer_if bus ();

    vector_lane_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Lane ALUs: each lane adds its two operands.
    always_comb begin
        bus.lane_result = '0;
        for (int l = 0; l < LANE_NUM; l++) begin
            bus.lane_result[l*LEN +: LEN] = bus.lane_vs1[l*LEN +: LEN] + bus.lane_vs2[l*LEN +: LEN];
        end
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        vec_t                   data;
        logic [VECTOR_SIZE-1:0] we;
        string                  name;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // element i = a*i + b where we[i] is set, else 0
    function automatic vec_t mk(input int a, input int b, input logic [VECTOR_SIZE-1:0] sel);
        vec_t v;
        v = '0;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            if (sel[i]) v[i*LEN +: LEN] = 32'(a * i + b);
        end
        return v;
    endfunction

    // Writeback monitor: compares every completed handshake against the scoreboard.
    initial begin
        exp_t got_e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.result_valid && bus.result_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    got_e = sb_q.pop_front();
                    check($sformatf("%s_data", got_e.name), bus.result_data, got_e.data);
                    check($sformatf("%s_we", got_e.name), bus.result_we, got_e.we);
                end
            end
        end
    end

    task automatic drive_idle();
        bus.start_valid      = 1'b0;
        bus.vl               = '0;
        bus.vm               = 1'b0;
        bus.mask_bits        = '0;
        bus.vs1_data         = '0;
        bus.vs2_data         = '0;
        bus.imm              = '0;
        bus.rs               = '0;
        bus.alu_signal       = '0;
        bus.vec_operand_type = '0;
        bus.funct6           = '0;
    endtask

    task automatic run_instr(input string name, input vl_t vl, input logic vm,
                             input logic [VECTOR_SIZE-1:0] mask, input vec_t vs1, input vec_t vs2,
                             input vec_t exp_data, input logic [VECTOR_SIZE-1:0] exp_we,
                             input int exp_cycles, input logic [LANE_NUM-1:0] exp_last, input int stall);
        int                  cycles;
        logic [LANE_NUM-1:0] last_act;
        logic [LEN-1:0]      imm_v;
        vec_t                hold;
        logic                stable;
        imm_v = 32'hA5A5_0000 | 32'(exp_we);
        @(negedge clk);
        bus.start_valid      = 1'b1;
        bus.vl               = vl;
        bus.vm               = vm;
        bus.mask_bits        = mask;
        bus.vs1_data         = vs1;
        bus.vs2_data         = vs2;
        bus.imm              = imm_v;
        bus.rs               = ~imm_v;
        bus.alu_signal       = 3'b101;
        bus.vec_operand_type = 2'b10;
        bus.funct6           = 6'h2A;
        check($sformatf("%s_start_ready", name), bus.start_ready, 1);
        sb_q.push_back('{data: exp_data, we: exp_we, name: name});
        @(posedge clk);
        #1;
        // Upstream is free to change everything once accepted.
        bus.start_valid = 1'b0;
        bus.vs1_data    = {VECTOR_SIZE{32'hDEAD_BEEF}};
        bus.vs2_data    = {VECTOR_SIZE{32'h0000_0001}};
        bus.vm          = ~vm;
        bus.mask_bits   = ~mask;
        bus.vl          = vl_t'(1);
        bus.imm         = '0;
        cycles   = 0;
        last_act = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.result_valid) break;
            if (cycles == 0) begin
                check($sformatf("%s_lane_imm", name), bus.lane_imm, imm_v);
                check($sformatf("%s_lane_funct6", name), bus.lane_funct6, 6'h2A);
            end
            cycles++;
            last_act = bus.lane_active;
        end
        check($sformatf("%s_result_valid", name), bus.result_valid, 1);
        check($sformatf("%s_exec_cycles", name), cycles, exp_cycles);
        check($sformatf("%s_last_active", name), last_act, exp_last);
        check($sformatf("%s_done_lanes_idle", name), {bus.lane_active, bus.lane_vs1}, 0);
        check($sformatf("%s_done_busy", name), bus.busy, 1);
        hold   = bus.result_data;
        stable = 1'b1;
        for (int k = 0; k < stall; k++) begin
            if (bus.result_data !== hold || bus.start_ready !== 1'b0 || bus.result_valid !== 1'b1)
                stable = 1'b0;
            @(negedge clk);
        end
        if (stall > 0) check($sformatf("%s_stall_stable", name), stable, 1);
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
        check($sformatf("%s_post_ready", name), {bus.start_ready, bus.result_valid, bus.busy}, 3'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.result_ready = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_start_ready", bus.start_ready, 1);
        check("reset_valid_busy", {bus.result_valid, bus.busy}, 0);
        check("reset_result", {bus.result_data, bus.result_we}, 0);
        check("reset_lanes", {bus.lane_active, bus.lane_vs1, bus.lane_imm}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr("add8", 4'd8, 1'b1, 8'h00, mk(1, 0, 8'hFF), mk(0, 10, 8'hFF),
                  mk(1, 10, 8'hFF), 8'hFF, 4, 2'b11, 0);

`ifdef VECTOR_SEQ_GROUP_SKIP_EN
        run_instr("mask5", 4'd5, 1'b0, 8'b1010_1010, mk(1, 0, 8'hFF), mk(0, 10, 8'hFF),
                  mk(1, 10, 8'b0000_1010), 8'b0000_1010, 2, 2'b11, 0);
`else
        run_instr("mask5", 4'd5, 1'b0, 8'b1010_1010, mk(1, 0, 8'hFF), mk(0, 10, 8'hFF),
                  mk(1, 10, 8'b0000_1010), 8'b0000_1010, 3, 2'b01, 0);
`endif

        run_instr("vl0", 4'd0, 1'b1, 8'hFF, mk(1, 0, 8'hFF), mk(0, 10, 8'hFF),
                  '0, 8'h00, 0, 2'b00, 0);

        run_instr("stall", 4'd8, 1'b1, 8'h00, mk(100, 0, 8'hFF), mk(1, 0, 8'hFF),
                  mk(101, 0, 8'hFF), 8'hFF, 4, 2'b11, 5);

        // Reset during the second EXEC cycle discards the instruction.
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.vl          = 4'd8;
        bus.vm          = 1'b1;
        bus.vs1_data    = mk(1, 0, 8'hFF);
        bus.vs2_data    = mk(0, 10, 8'hFF);
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        @(negedge clk);
        check("rst_exec1_active", bus.lane_active, 2'b11);
        @(negedge clk);
        check("rst_exec2_active", bus.lane_active, 2'b11);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_mid_ctrl", {bus.start_ready, bus.result_valid, bus.busy}, 3'b100);
        check("rst_mid_lanes", {bus.lane_active, bus.lane_vs1, bus.lane_vs2, bus.lane_mask}, 0);
        check("rst_mid_result", {bus.result_data, bus.result_we}, 0);
        drive_idle();

        run_instr("post_rst", 4'd3, 1'b1, 8'h00, mk(1, 1, 8'hFF), mk(2, 0, 8'hFF),
                  mk(3, 1, 8'b0000_0111), 8'b0000_0111, 2, 2'b01, 0);

`ifdef VECTOR_SEQ_GROUP_SKIP_EN
        run_instr("skip", 4'd8, 1'b0, 8'b1100_0000, mk(1, 0, 8'hFF), mk(0, 10, 8'hFF),
                  mk(1, 10, 8'b1100_0000), 8'b1100_0000, 1, 2'b11, 0);
        run_instr("allmask", 4'd6, 1'b0, 8'h00, mk(1, 0, 8'hFF), mk(0, 10, 8'hFF),
                  '0, 8'h00, 0, 2'b00, 0);
`else
        run_instr("skip", 4'd8, 1'b0, 8'b1100_0000, mk(1, 0, 8'hFF), mk(0, 10, 8'hFF),
                  mk(1, 10, 8'b1100_0000), 8'b1100_0000, 4, 2'b11, 0);
        run_instr("allmask", 4'd6, 1'b0, 8'h00, mk(1, 0, 8'hFF), mk(0, 10, 8'hFF),
                  '0, 8'h00, 3, 2'b11, 0);
`endif

        run_instr("clamp", 4'd12, 1'b1, 8'h00, mk(1, 0, 8'hFF), mk(0, 0, 8'hFF),
                  mk(1, 0, 8'hFF), 8'hFF, 4, 2'b11, 0);

        repeat (2) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
